multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_pkg.sv | 70 +++++++
 rtl/control_decode.sv | 86 ++++++++
 rtl/multicycle_control.sv | 113 +++++++++++
 tb/tb_multicycle_control.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode
// constants and the mux/ALU select encodings used by the datapath.
package multicycle_pkg;

    localparam int OP_W = 6;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        IMM_EXEC  = 4'd11,
        IMM_WB    = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] R_TYPE = 6'b000000;
    localparam logic [OP_W-1:0] LW     = 6'b100011;
    localparam logic [OP_W-1:0] SW     = 6'b101011;
    localparam logic [OP_W-1:0] BEQ    = 6'b000100;
    localparam logic [OP_W-1:0] J      = 6'b000010;
    localparam logic [OP_W-1:0] ADDI   = 6'b001000;

    // PC source mux select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    // ALU control request
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [OP_W-1:0] op);
        return op inside {R_TYPE, LW, SW, BEQ, J, ADDI};
    endfunction

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == LW) || (op == SW);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Per-state control word decode. Purely combinational; FETCH is the only
// state whose outputs also depend on the memory handshake.
module control_decode
    import multicycle_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Map the current state (and MemReady during FETCH) to the control word
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // Latch the instruction and advance PC only once the read lands
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                // Branch target computed speculatively into the ALU register
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SHIFT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            BRANCH: begin
                // PC update is qualified by Zero outside this block
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            IMM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main controller: state register, next-state logic and
// illegal-opcode detection. Control outputs come from control_decode, so an
// asynchronous reset forces IDLE and therefore clears every strobe at once.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  IDLE      | post-reset, all outputs low
//  FETCH     | read instruction, PC+4 (waits for MemReady)
//  DECODE    | register read, branch target, opcode dispatch
//  MEM_ADDR  | effective address for lw/sw
//  MEM_READ  | data read (waits for MemReady)
//  MEM_WB    | load result into register file
//  MEM_WRITE | data write (waits for MemReady)
//  EXECUTE   | R-type ALU operation
//  R_WB      | R-type result into rd
//  BRANCH    | compare, conditional PC write
//  JUMP      | PC <= jump target
//  IMM_EXEC  | addi ALU operation
//  IMM_WB    | addi result into rt
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    input  logic                    Zero,
    input  logic                    MemReady,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic [1:0]              PCSource,
    output logic                    IorD,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    RegDst,
    output logic                    RegWrite,
    output logic                    MemToReg,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic                    Illegal,
    output logic [3:0]              State
);

    state_t          state;
    ctrl_t           ctrl;
    logic [OP_W-1:0] opcode;

    assign opcode = OP_W'(Opcode);

    // State register and next-state selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      state <= FETCH;
                FETCH:     if (MemReady) state <= DECODE;
                DECODE: begin
                    if (opcode == R_TYPE)     state <= EXECUTE;
                    else if (is_mem_op(opcode)) state <= MEM_ADDR;
                    else if (opcode == BEQ)   state <= BRANCH;
                    else if (opcode == J)     state <= JUMP;
                    else if (opcode == ADDI)  state <= IMM_EXEC;
                    else                      state <= FETCH;
                end
                // Opcode is stable here and is known to be lw or sw
                MEM_ADDR:  state <= (opcode == LW) ? MEM_READ : MEM_WRITE;
                MEM_READ:  if (MemReady) state <= MEM_WB;
                MEM_WRITE: if (MemReady) state <= FETCH;
                EXECUTE:   state <= R_WB;
                IMM_EXEC:  state <= IMM_WB;
                MEM_WB, R_WB, BRANCH, JUMP, IMM_WB: state <= FETCH;
                default:   state <= IDLE;
            endcase
        end
    end

    control_decode u_decode (
        .state     (state),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCSource    = ctrl.pc_source;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign MemToReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;

    // Illegal is only meaningful while the opcode is being dispatched
    assign Illegal = (state == DECODE) && !is_supported(opcode);
    assign State   = state;

    // The two PC write enables are mutually exclusive by construction
    a_pc_write_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(PCWrite && PCWriteCond));

    // Zero gates the PC externally; it must be a defined level when branching
    a_zero_known: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BRANCH) |-> !$isunknown(Zero));

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: latency table, hand-written corner sequences
// and a randomized run against an instruction-path reference model.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, RegWrite, MemToReg, ALUSrcA, Illegal;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] State;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [5:0] op;
        int         cycles;
        int         pcw;
        int         ill;
    } vec_t;
    vec_t vecs[8];

    state_t     path[$];
    state_t     exp_s;
    logic [5:0] cur_op;
    int         cyc, pcw, ill;

    multicycle_control #(.OPCODE_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .Illegal(Illegal), .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] outs();
        return {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                RegDst, RegWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp, Illegal};
    endfunction

    function automatic logic supported(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
    endfunction

    // Expected control word, written field by field from the state descriptions
    function automatic logic [16:0] exp_outs(input state_t s, input logic mr, input logic [5:0] op);
        logic       pcw_e = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic       rdst = 0, rw = 0, m2r = 0, asa = 0, illg = 0;
        logic [1:0] pcs = 0, asb = 0, aop = 0;
        if (s == FETCH)     begin mrd = 1; asb = 2'b01; irw = mr; pcw_e = mr; end
        if (s == DECODE)    begin asb = 2'b11; illg = !supported(op); end
        if (s == MEM_ADDR)  begin asa = 1; asb = 2'b10; end
        if (s == MEM_READ)  begin mrd = 1; iord = 1; end
        if (s == MEM_WRITE) begin mwr = 1; iord = 1; end
        if (s == MEM_WB)    begin rw = 1; m2r = 1; end
        if (s == EXECUTE)   begin asa = 1; aop = 2'b10; end
        if (s == R_WB)      begin rw = 1; rdst = 1; end
        if (s == BRANCH)    begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
        if (s == JUMP)      begin pcw_e = 1; pcs = 2'b10; end
        if (s == IMM_EXEC)  begin asa = 1; asb = 2'b10; end
        if (s == IMM_WB)    begin rw = 1; end
        return {pcw_e, pcwc, pcs, iord, mrd, mwr, irw, rdst, rw, m2r, asa, asb, aop, illg};
    endfunction

    // Sequence of states an instruction visits, ignoring memory wait cycles
    function automatic void load_path(input logic [5:0] op);
        path.delete();
        path.push_back(FETCH);
        path.push_back(DECODE);
        case (op)
            6'h00: begin path.push_back(EXECUTE); path.push_back(R_WB); end
            6'h23: begin path.push_back(MEM_ADDR); path.push_back(MEM_READ); path.push_back(MEM_WB); end
            6'h2b: begin path.push_back(MEM_ADDR); path.push_back(MEM_WRITE); end
            6'h04: path.push_back(BRANCH);
            6'h02: path.push_back(JUMP);
            6'h08: begin path.push_back(IMM_EXEC); path.push_back(IMM_WB); end
            default: ;
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
        if ($urandom_range(0, 9) < 8) return legal_ops[$urandom_range(0, 5)];
        return 6'($urandom);
    endfunction

    task automatic cycle(input logic mr, input logic z);
        @(negedge clk);
        MemReady = mr;
        Zero     = z;
        #1;
    endtask

    // Hold reset for 3 cycles (with MemReady high), release, see IDLE then FETCH
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("reset_outputs", 32'(outs()), 32'd0);
            check("reset_state", 32'(State), 32'(IDLE));
            @(negedge clk);
        end
        rst_n = 1'b1; MemReady = 1'b0; Zero = 1'b0;
        #1;
        check("release_idle", 32'(State), 32'(IDLE));
        check("release_idle_outputs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        check("first_edge_fetch", 32'(State), 32'(FETCH));
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; Opcode = 6'h00; Zero = 1'b0; MemReady = 1'b0;

        vecs[0] = '{6'h00, 4, 1, 0};
        vecs[1] = '{6'h23, 5, 1, 0};
        vecs[2] = '{6'h2b, 4, 1, 0};
        vecs[3] = '{6'h08, 4, 1, 0};
        vecs[4] = '{6'h04, 3, 1, 0};
        vecs[5] = '{6'h02, 3, 2, 0};
        vecs[6] = '{6'h3f, 2, 1, 1};
        vecs[7] = '{6'h11, 2, 1, 1};

        // Latency table with MemReady always high
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Opcode = vecs[i].op; MemReady = 1'b1; Zero = 1'b0;
            cyc = 0; pcw = 0; ill = 0;
            do begin
                #1;
                cyc++;
                pcw += int'(PCWrite);
                ill += int'(Illegal);
                @(negedge clk);
            end while (State != FETCH && cyc < 20);
            check($sformatf("latency_op%0h", vecs[i].op), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("pcwrite_cycles_op%0h", vecs[i].op), 32'(pcw), 32'(vecs[i].pcw));
            check($sformatf("illegal_cycles_op%0h", vecs[i].op), 32'(ill), 32'(vecs[i].ill));
        end

        // R-type walk
        do_reset(); Opcode = 6'h00;
        cycle(1, 0); check("r_fetch", 32'(State), 32'(FETCH));
        cycle(1, 0); check("r_decode", 32'(State), 32'(DECODE));
        cycle(1, 0); check("r_execute", 32'(State), 32'(EXECUTE));
        check("r_execute_nowrite", 32'({RegWrite, RegDst}), 32'd0);
        cycle(1, 0); check("r_wb", 32'(State), 32'(R_WB));
        check("r_wb_controls", 32'({RegWrite, RegDst, MemToReg}), 32'b110);
        cycle(1, 0); check("r_back_fetch", 32'(State), 32'(FETCH));
        check("r_fetch_nowrite", 32'({RegWrite, RegDst}), 32'd0);

        // lw with three wait cycles in MEM_READ
        do_reset(); Opcode = 6'h23;
        cycle(1, 0); check("lw_fetch", 32'(State), 32'(FETCH));
        cycle(1, 0); check("lw_decode", 32'(State), 32'(DECODE));
        cycle(1, 0); check("lw_mem_addr", 32'(State), 32'(MEM_ADDR));
        for (int k = 0; k < 4; k++) begin
            cycle(k == 3, 0);
            check("lw_mem_read_hold", 32'(State), 32'(MEM_READ));
            check("lw_read_strobes", 32'({MemRead, IorD, RegWrite}), 32'b110);
        end
        cycle(1, 0); check("lw_mem_wb", 32'(State), 32'(MEM_WB));
        check("lw_wb_controls", 32'({RegWrite, MemToReg, RegDst}), 32'b110);
        cycle(1, 0); check("lw_back_fetch", 32'(State), 32'(FETCH));

        // beq taken and not taken: controller output identical
        for (int z = 1; z >= 0; z--) begin
            do_reset(); Opcode = 6'h04;
            cycle(1, 1'(z)); check("beq_fetch", 32'(State), 32'(FETCH));
            cycle(1, 1'(z)); check("beq_decode", 32'(State), 32'(DECODE));
            cycle(1, 1'(z)); check("beq_branch", 32'(State), 32'(BRANCH));
            check($sformatf("beq_controls_zero%0d", z),
                  32'({PCWriteCond, PCSource, PCWrite}), 32'b1010);
            cycle(1, 1'(z)); check("beq_back_fetch", 32'(State), 32'(FETCH));
        end

        // jump followed by an illegal opcode
        do_reset(); Opcode = 6'h02;
        cycle(1, 0); check("j_fetch", 32'(State), 32'(FETCH));
        cycle(1, 0); check("j_decode", 32'(State), 32'(DECODE));
        cycle(1, 0); check("j_jump", 32'(State), 32'(JUMP));
        check("j_controls", 32'({PCWrite, PCSource, PCWriteCond}), 32'b1100);
        cycle(1, 0); check("j_back_fetch", 32'(State), 32'(FETCH));
        check("ill_low_in_fetch", 32'(Illegal), 32'd0);
        Opcode = 6'h3f;
        cycle(1, 0); check("ill_decode", 32'(State), 32'(DECODE));
        check("ill_pulse", 32'(Illegal), 32'd1);
        cycle(1, 0); check("ill_back_fetch", 32'(State), 32'(FETCH));
        check("ill_pulse_ends", 32'(Illegal), 32'd0);

        // asynchronous reset while a write is waiting on memory
        do_reset(); Opcode = 6'h2b;
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        cycle(0, 0); check("sw_mem_write", 32'(State), 32'(MEM_WRITE));
        check("sw_write_strobe", 32'(MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_memwrite_drop", 32'(MemWrite), 32'd0);
        check("async_state_idle", 32'(State), 32'(IDLE));
        check("async_all_outputs", 32'(outs()), 32'd0);

        // randomized instruction stream against the path model
        do_reset();
        path.delete();
        cur_op = 6'h00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (path.size() == 0) begin
                cur_op = pick_op();
                Opcode = cur_op;
                load_path(cur_op);
            end
            MemReady = ($urandom_range(0, 99) < 65);
            Zero     = 1'($urandom_range(0, 1));
            #1;
            exp_s = path[0];
            check("random_cycle", 32'({State, outs()}),
                  32'({4'(exp_s), exp_outs(exp_s, MemReady, cur_op)}));
            if (!((exp_s == FETCH || exp_s == MEM_READ || exp_s == MEM_WRITE) && !MemReady))
                void'(path.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
